clb_config_loader: RTL

//   Serial configuration writer for a chain of CLBs. Receives a bitstream one bit per

---
 rtl/clb_config_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/clb_config_loader.sv
// Serial configuration loader: shifts a bitstream into a shadow register and commits it
// to all CLB prog words at once. Define CFG_PARITY_EN to append a checked even-parity bit.
module clb_config_loader #(
    parameter int NUM_CLB = 4,
    parameter int CFG_W   = 17
) (
    input  logic                     clb_clk,
    input  logic                     rst,
    input  logic                     cfg_start,
    input  logic                     cfg_valid,
    input  logic                     cfg_bit,
    output logic                     cfg_ready,
    output logic [NUM_CLB*CFG_W-1:0] prog_bus,
    output logic                     cfg_busy,
    output logic                     cfg_done,
    output logic                     cfg_error
);

    localparam int TOTAL = NUM_CLB * CFG_W;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

`ifdef CFG_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, APPLY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, APPLY} state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [TOTAL-1:0] shadow;
    logic [TOTAL-1:0] shadow_next;
    logic [TOTAL-1:0] prog_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] bit_cnt_next;
    logic             ready_next;
    logic             busy_next;
    logic             done_next;
    logic             accept;
    logic             last_bit;

    assign accept   = cfg_valid && cfg_ready;
    assign last_bit = (bit_cnt == LAST_IDX);

`ifdef CFG_PARITY_EN
    logic parity_ok;
    logic error_next;

    // Shadow already holds every data bit when the parity bit arrives.
    assign parity_ok = ~(^shadow ^ cfg_bit);
`else
    assign cfg_error = 1'b0;
`endif

    always_ff @(posedge clb_clk) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            bit_cnt   <= '0;
            prog_bus  <= '0;
            cfg_ready <= 1'b0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
`ifdef CFG_PARITY_EN
            cfg_error <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            shadow    <= shadow_next;
            bit_cnt   <= bit_cnt_next;
            prog_bus  <= prog_next;
            cfg_ready <= ready_next;
            cfg_busy  <= busy_next;
            cfg_done  <= done_next;
`ifdef CFG_PARITY_EN
            cfg_error <= error_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cfg_start)
                    state_next = SHIFT;
            end
            SHIFT: begin
                if (cfg_start)
                    state_next = SHIFT;
                else if (accept && last_bit)
`ifdef CFG_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = APPLY;
`endif
            end
`ifdef CFG_PARITY_EN
            PARITY: begin
                if (cfg_start)
                    state_next = SHIFT;
                else if (accept)
                    state_next = parity_ok ? APPLY : IDLE;
            end
`endif
            APPLY:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed from the next state so every output leaves a flop.
    always_comb begin
        shadow_next  = shadow;
        bit_cnt_next = bit_cnt;
        prog_next    = prog_bus;
        done_next    = 1'b0;
`ifdef CFG_PARITY_EN
        error_next   = cfg_error;
`endif
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    bit_cnt_next = '0;
`ifdef CFG_PARITY_EN
                    error_next   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (cfg_start) begin
                    bit_cnt_next = '0;
                end else if (accept) begin
                    shadow_next  = {shadow[TOTAL-2:0], cfg_bit};
                    bit_cnt_next = bit_cnt + CNT_W'(1);
                end
            end
`ifdef CFG_PARITY_EN
            PARITY: begin
                if (cfg_start)
                    bit_cnt_next = '0;
                else if (accept && !parity_ok)
                    error_next = 1'b1;
            end
`endif
            APPLY: begin
                prog_next = shadow;
                done_next = 1'b1;
            end
            default: begin
                bit_cnt_next = '0;
            end
        endcase

`ifdef CFG_PARITY_EN
        ready_next = (state_next == SHIFT) || (state_next == PARITY);
`else
        ready_next = (state_next == SHIFT);
`endif
        busy_next  = (state_next != IDLE);
    end

endmodule
